serial_add_sub: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/serial_add_sub_if.sv | 24 ++
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_add_sub.sv | 84 ++++++++
 tb/tb_serial_add_sub.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic block: FSM state encoding and operation codes.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle for serial_add_sub; master issues operands, slave returns the result.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder: the single arithmetic slice reused every cycle by serial_add_sub.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a single
// full-adder slice with a registered carry; result, carry-out and overflow land with done.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_sub_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s;
  logic             c;

  full_adder_bit u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (s),
    .cout (c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      acc          <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_sh     <= bus.a;
            b_sh     <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry    <= (bus.sub == OP_SUB);
            cnt      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= {s, acc[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // carry still holds the carry into the MSB while c is the carry out of it.
            bus.result   <= {s, acc[WIDTH-1:1]};
            bus.cout     <= c;
            bus.overflow <= carry ^ c;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed and random operations against a plain-arithmetic model.
module tb_serial_add_sub;
  import serial_arith_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, sres;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (s == OP_ADD) begin
      r    = 8'((ua + ub) % 256);
      co   = (ua + ub) > 255;
      sres = sa + sb;
    end else begin
      r    = 8'((ua - ub + 256) % 256);
      co   = (ua >= ub);
      sres = sa - sb;
    end
    ov = (sres > 127) || (sres < -128);
  endfunction

  // Drives one request and watches until done (bounded); called with clk low.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int busy_cyc, output int done_cyc, output logic [7:0] r,
                       output logic co, output logic ov, output logic both);
    bus.a = a; bus.b = b; bus.sub = s; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.sub = 1'($urandom);
    busy_cyc = 0; done_cyc = 0; both = 1'b0; r = 'x; co = 1'bx; ov = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.done) both = 1'b1;
      if (bus.done) begin
        done_cyc = i; r = bus.result; co = bus.cout; ov = bus.overflow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.result !== 8'h00) begin n_bad++; $display("FAIL reset_result got=%h exp=00", bus.result); end
    n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] va [5] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80};
    logic [7:0] vb [5] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01};
    logic       vs [5] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [7:0] er [5] = '{8'h7F, 8'h00, 8'h80, 8'hF0, 8'h7F};
    logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int bc, dc; logic [7:0] r; logic co, ov, both;
    for (int k = 0; k < 5; k++) begin
      do_op(va[k], vb[k], vs[k], bc, dc, r, co, ov, both);
      n_cmp++; if (r !== er[k]) begin n_bad++; $display("FAIL dir%0d_result got=%h exp=%h", k, r, er[k]); end
      n_cmp++; if (co !== ec[k]) begin n_bad++; $display("FAIL dir%0d_cout got=%b exp=%b", k, co, ec[k]); end
      n_cmp++; if (ov !== eo[k]) begin n_bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", k, ov, eo[k]); end
      n_cmp++; if (bc != W) begin n_bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", k, bc, W); end
      n_cmp++; if (dc != W + 1) begin n_bad++; $display("FAIL dir%0d_done_latency got=%0d exp=%0d", k, dc, W + 1); end
      n_cmp++; if (both !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_and_done got=%b exp=0", k, both); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int bc, dc; logic [7:0] a, b, r, er; logic s, co, ov, ec, eo, both;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      model(a, b, s, er, ec, eo);
      do_op(a, b, s, bc, dc, r, co, ov, both);
      n_cmp++; if ({r, co, ov} !== {er, ec, eo})
        begin n_bad++; $display("FAIL rnd%0d a=%h b=%h sub=%b got r=%h c=%b v=%b exp r=%h c=%b v=%b",
                                k, a, b, s, r, co, ov, er, ec, eo); end
      n_cmp++; if (dc != W + 1) begin n_bad++; $display("FAIL rnd%0d_done_latency got=%0d exp=%0d", k, dc, W + 1); end
      // Every other op is issued straight from the DONE cycle.
      if (k % 2 == 1) @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0, bc = 0; logic [7:0] r = 'x;
    bus.a = 8'h35; bus.b = 8'h4A; bus.sub = OP_ADD; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin pulses++; r = bus.result; end
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; end
      if (i == 4) bus.start = 1'b0;
    end
    n_cmp++; if (r !== 8'h7F) begin n_bad++; $display("FAIL ignore_result got=%h exp=7f", r); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ignore_done_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (bc != W) begin n_bad++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", bc, W); end
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0, pulses = 0, bad_busy = 0;
    logic [7:0] r1 = 'x, r2 = 'x; logic c2 = 1'bx, v2 = 1'bx;
    bus.a = 8'h35; bus.b = 8'h4A; bus.sub = OP_ADD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h10; bus.b = 8'h20; bus.sub = OP_SUB;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i <= 2 * W + 2 && bus.busy === bus.done) bad_busy++;
      if (bus.done) begin
        pulses++;
        if (pulses == 1) begin d1 = i; r1 = bus.result; end
        else begin d2 = i; r2 = bus.result; c2 = bus.cout; v2 = bus.overflow; end
      end
      if (i == W + 2) bus.start = 1'b0;
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    n_cmp++; if (d2 - d1 != W + 1) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", d2 - d1, W + 1); end
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL b2b_busy_not_complement got=%0d exp=0", bad_busy); end
    n_cmp++; if (r1 !== 8'h7F) begin n_bad++; $display("FAIL b2b_result1 got=%h exp=7f", r1); end
    n_cmp++; if ({r2, c2, v2} !== {8'hF0, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL b2b_result2 got r=%h c=%b v=%b exp r=f0 c=0 v=0", r2, c2, v2); end
  endtask

  task automatic test_midrun_reset();
    int pulses = 0, bc, dc; logic [7:0] r; logic co, ov, both;
    // Leave a nonzero result/cout/overflow behind so the reset is observable.
    do_op(8'h80, 8'h01, OP_SUB, bc, dc, r, co, ov, both);
    @(negedge clk);
    bus.a = 8'h35; bus.b = 8'h4A; bus.sub = OP_ADD; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.result, bus.cout, bus.overflow} !== 12'h000)
      begin n_bad++; $display("FAIL midrst_outputs got busy=%b done=%b r=%h c=%b v=%b exp all 0",
                              bus.busy, bus.done, bus.result, bus.cout, bus.overflow); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus.done || bus.busy) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midrst_activity got=%0d exp=0", pulses); end
    do_op(8'h35, 8'h4A, OP_ADD, bc, dc, r, co, ov, both);
    n_cmp++; if ({r, co, ov} !== {8'h7F, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL midrst_after got r=%h c=%b v=%b exp r=7f c=0 v=0", r, co, ov); end
    n_cmp++; if (dc != W + 1) begin n_bad++; $display("FAIL midrst_latency got=%0d exp=%0d", dc, W + 1); end
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = OP_ADD; bus.a = '0; bus.b = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
